// File: rtl/rst_ctrl.sv
// ============================================================================
// Module   : rst_ctrl
// Brief    : Reset sequencer with minimum hold, staged release (mem, periph,
//            core) and a sticky cause register. Optional debounced pushbutton
//            source enabled by defining RST_CTRL_EXT_BTN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_ctrl #(
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_CYCLES = 4
`ifdef RST_CTRL_EXT_BTN_EN
  ,
  parameter int DEBOUNCE_CYCLES = 1024
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_por,
  input  logic       i_wdt_req,
  input  logic       i_sw_req,
`ifdef RST_CTRL_EXT_BTN_EN
  input  logic       i_btn_n,
`endif
  input  logic       i_cause_clr,
  output logic       o_mem_rst_n,
  output logic       o_periph_rst_n,
  output logic       o_core_rst_n,
  output logic       o_ready,
  output logic [3:0] o_cause
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LOAD = CW'(STAGE_CYCLES - 1);

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    MEM_UP = 2'd1,
    PER_UP = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            mem_d, per_d, core_d, ready_d;
  logic [3:0]      cause_d;
  logic            btn_req;
  logic [3:0]      src;
  logic            req;

`ifdef RST_CTRL_EXT_BTN_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    btn_sync;
  logic [DW-1:0] db_cnt;

  // Counter saturates at DB_MAX so btn_req stays up while the button is held.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      btn_sync <= 2'b11;
      db_cnt   <= '0;
    end else begin
      btn_sync <= {btn_sync[0], i_btn_n};
      if (btn_sync[1])
        db_cnt <= '0;
      else if (db_cnt != DB_MAX)
        db_cnt <= db_cnt + DW'(1);
    end
  end

  assign btn_req = (db_cnt == DB_MAX);
`else
  assign btn_req = 1'b0;
`endif

  assign src = {btn_req, i_sw_req, i_wdt_req, i_por};
  assign req = |src;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mem_d   = o_mem_rst_n;
    per_d   = o_periph_rst_n;
    core_d  = o_core_rst_n;
    ready_d = o_ready;
    cause_d = o_cause;
    if (req) begin
      state_d = ASSERT;
      cnt_d   = HOLD_LOAD;
      mem_d   = 1'b0;
      per_d   = 1'b0;
      core_d  = 1'b0;
      ready_d = 1'b0;
      // A clear in the same RUN cycle drops old bits; the new sources win.
      cause_d = (state == RUN && i_cause_clr) ? src : (o_cause | src);
    end else begin
      unique case (state)
        ASSERT: begin
          if (cnt == '0) begin
            state_d = MEM_UP;
            cnt_d   = STAGE_LOAD;
            mem_d   = 1'b1;
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
        MEM_UP: begin
          if (cnt == '0) begin
            state_d = PER_UP;
            cnt_d   = STAGE_LOAD;
            per_d   = 1'b1;
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
        PER_UP: begin
          if (cnt == '0) begin
            state_d = RUN;
            core_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
        RUN: begin
          if (i_cause_clr)
            cause_d = 4'b0000;
        end
        default: state_d = ASSERT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= ASSERT;
      cnt            <= HOLD_LOAD;
      o_mem_rst_n    <= 1'b0;
      o_periph_rst_n <= 1'b0;
      o_core_rst_n   <= 1'b0;
      o_ready        <= 1'b0;
      o_cause        <= 4'b0001;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      o_mem_rst_n    <= mem_d;
      o_periph_rst_n <= per_d;
      o_core_rst_n   <= core_d;
      o_ready        <= ready_d;
      o_cause        <= cause_d;
    end
  end

endmodule

`default_nettype wire
